// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write FIFO between the CPU data port and the DM SRAM; loads have port priority.
// Optional STB_FWD_EN: full-word load hits are served from the youngest matching entry.
module dm_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_memread,
  input  logic                  cpu_memwrite,
  input  logic [DATA_W/8-1:0]   cpu_wen,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  output logic                  sb_empty,
  input  logic                  sram_gnt,
  output logic                  sram_cs,
  output logic                  sram_oe,
  output logic [DATA_W/8-1:0]   sram_web,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_di,
  input  logic [DATA_W-1:0]     sram_do
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = DATA_W / 8;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [BW-1:0]     web_q  [DEPTH];
  logic [BW-1:0]     web_d  [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              hit, fwd, drain, accept;
  logic [DATA_W-1:0] fwd_data;
`ifdef STB_FWD_EN
  logic              y_full;
`endif
  // Walk entries oldest to youngest so the last match is the youngest one.
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
`ifdef STB_FWD_EN
    y_full = 1'b0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q && addr_q[head_q + PW'(k)] == cpu_addr) begin
        hit = cpu_memread;
`ifdef STB_FWD_EN
        y_full = web_q[head_q + PW'(k)] == '0;
        fwd_data = data_q[head_q + PW'(k)];
`endif
      end
    end
`ifdef STB_FWD_EN
    fwd = hit & y_full;
`else
    fwd = 1'b0;
`endif
  end
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    sram_cs = 1'b0;
    sram_oe = 1'b0;
    sram_web = '1;
    sram_addr = '0;
    sram_di = '0;
    drain = 1'b0;
    if (cpu_memread) begin
      if (fwd) begin
        cpu_rdata = fwd_data;
        drain = sram_gnt && count_q != '0;
      end else if (sram_gnt && !hit) begin
        sram_cs = 1'b1;
        sram_oe = 1'b1;
        sram_addr = cpu_addr;
        cpu_rdata = sram_do;
      end else begin
        cpu_stall = 1'b1;
        drain = hit && sram_gnt;
      end
    end else begin
      drain = sram_gnt && count_q != '0;
    end
    if (drain) begin
      sram_cs = 1'b1;
      sram_web = web_q[head_q];
      sram_addr = addr_q[head_q];
      sram_di = data_q[head_q];
    end
    accept = cpu_memwrite && (count_q != CW'(DEPTH) || drain);
    if (cpu_memwrite && !accept) cpu_stall = 1'b1;
    addr_d = addr_q;
    data_d = data_q;
    web_d = web_q;
    if (accept) begin
      addr_d[tail_q] = cpu_addr;
      data_d[tail_q] = cpu_wdata;
      web_d[tail_q] = cpu_wen;
    end
    head_d = drain ? head_q + PW'(1) : head_q;
    tail_d = accept ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(accept) - CW'(drain);
  end
  assign sb_empty = count_q == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
        web_q[k] <= '1;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      addr_q <= addr_d;
      data_q <= data_d;
      web_q <= web_d;
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed and randomized checks of dm_store_buffer against a queue-based model.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst;
  logic        cpu_memread, cpu_memwrite, cpu_stall, sb_empty, sram_gnt, sram_cs, sram_oe;
  logic [3:0]  cpu_wen, sram_web;
  logic [13:0] cpu_addr, sram_addr;
  logic [31:0] cpu_wdata, cpu_rdata, sram_di, sram_do;
  int total = 0, bad = 0;
  typedef struct packed { logic [13:0] a; logic [31:0] d; logic [3:0] w; } ent_t;
  ent_t q[$];
  logic [13:0] wr_log[$];
  logic        s_stall, s_empty, s_cs, s_oe;
  logic [31:0] s_rdata;
  always #5 clk = ~clk;
  dm_store_buffer #(.DEPTH(DEPTH), .ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .sb_empty(sb_empty), .sram_gnt(sram_gnt), .sram_cs(sram_cs),
    .sram_oe(sram_oe), .sram_web(sram_web), .sram_addr(sram_addr), .sram_di(sram_di),
    .sram_do(sram_do)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", n, act, exp, $time);
    end
  endtask
  // Called at posedge+1; drives one cycle, checks all outputs vs model, advances model.
  task automatic step(input logic rd, input logic wr, input logic [3:0] wen, input logic [13:0] a,
                      input logic [31:0] wd, input logic g, input logic [31:0] sdo);
    logic hit, fwd, drain, acc, e_stall, e_cs, e_oe;
    logic [3:0] e_web;
    logic [13:0] e_addr;
    logic [31:0] e_rdata, e_di;
    int yi;
    cpu_memread = rd; cpu_memwrite = wr; cpu_wen = wen; cpu_addr = a;
    cpu_wdata = wd; sram_gnt = g; sram_do = sdo;
    #3;
    yi = -1;
    foreach (q[i]) if (q[i].a == a) yi = i;
    hit = rd && yi >= 0;
`ifdef STB_FWD_EN
    fwd = hit && q[yi].w == 4'h0;
`else
    fwd = 1'b0;
`endif
    e_stall = 0; e_rdata = 0; e_cs = 0; e_oe = 0; e_web = 4'hF; e_addr = 0; e_di = 0; drain = 0;
    if (rd && fwd) begin
      e_rdata = q[yi].d;
      drain = g && q.size() > 0;
    end else if (rd && g && !hit) begin
      e_cs = 1; e_oe = 1; e_addr = a; e_rdata = sdo;
    end else if (rd) begin
      e_stall = 1;
      drain = hit && g;
    end else drain = g && q.size() > 0;
    if (drain) begin
      e_cs = 1; e_web = q[0].w; e_addr = q[0].a; e_di = q[0].d;
    end
    acc = wr && (q.size() < DEPTH || drain);
    if (wr && !acc) e_stall = 1;
    chk("stall", 32'(cpu_stall), 32'(e_stall));
    chk("rdata", cpu_rdata, e_rdata);
    chk("empty", 32'(sb_empty), 32'(q.size() == 0));
    chk("cs", 32'(sram_cs), 32'(e_cs));
    chk("oe", 32'(sram_oe), 32'(e_oe));
    chk("web", 32'(sram_web), 32'(e_web));
    chk("saddr", 32'(sram_addr), 32'(e_addr));
    chk("di", sram_di, e_di);
    s_stall = cpu_stall; s_empty = sb_empty; s_cs = sram_cs; s_oe = sram_oe; s_rdata = cpu_rdata;
    if (sram_cs && !sram_oe) wr_log.push_back(sram_addr);
    if (drain) void'(q.pop_front());
    if (acc) q.push_back('{a: a, d: wd, w: wen});
    @(posedge clk); #1;
  endtask
  task automatic idle(input logic g);
    step(0, 0, 4'hF, 14'h0, 32'h0, g, 32'h0);
  endtask
  task automatic flush();
    for (int i = 0; i < DEPTH + 2; i++) idle(1);
    idle(0);
    chk("flush_empty", 32'(s_empty), 32'h1);
  endtask
  task automatic do_reset();
    cpu_memread = 0; cpu_memwrite = 0; sram_gnt = 1; rst = 1;
    #2;
    chk("rst_empty", 32'(sb_empty), 32'h1);
    chk("rst_web", 32'(sram_web), 32'hF);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_cs", 32'(sram_cs), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_saddr", 32'(sram_addr), 32'h0);
    q.delete();
    wr_log.delete();
    @(posedge clk); #1;
    rst = 0;
  endtask
  initial begin
    logic rd, wr, g;
    logic [3:0] wen;
    logic [13:0] a;
    logic [31:0] wd;
    cpu_memread = 0; cpu_memwrite = 0; cpu_wen = 4'hF; cpu_addr = 0; cpu_wdata = 0;
    sram_gnt = 0; sram_do = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // Reset with three stores pending
    for (int i = 0; i < 3; i++) step(0, 1, 4'h0, 14'(8 + i), 32'(i), 0, 0);
    do_reset();
    idle(1);
    chk("post_rst_cs", 32'(s_cs), 32'h0);
    chk("post_rst_empty", 32'(s_empty), 32'h1);
    // Fill while the port is owned elsewhere, then overflow
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 4'h0, 14'(i), 32'(i * 'h11), 0, 0);
      chk("fill_stall", 32'(s_stall), 32'h0);
    end
    step(0, 1, 4'h0, 14'd5, 32'h55, 0, 0);
    chk("full_stall", 32'(s_stall), 32'h1);
    wr_log.delete();
    step(0, 1, 4'h0, 14'd5, 32'h55, 1, 0);
    chk("full_accept", 32'(s_stall), 32'h0);
    chk("full_cnt", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) idle(1);
    chk("order_n", 32'(wr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("order", 32'(wr_log[i]), 32'(i + 1));
    idle(0);
    chk("drained_empty", 32'(s_empty), 32'h1);
    // Load hit stalls while the matching store drains
    step(0, 1, 4'h0, 14'h20, 32'hCAFEF00D, 0, 0);
    step(1, 0, 4'hF, 14'h20, 32'h0, 1, 32'h0BADBEEF);
    chk("hit_stall", 32'(s_stall), 32'h1);
    chk("hit_drain", 32'(s_cs & ~s_oe), 32'h1);
    step(1, 0, 4'hF, 14'h20, 32'h0, 1, 32'hA5A5A5A5);
    chk("hit_oe", 32'(s_oe), 32'h1);
    chk("hit_rdata", s_rdata, 32'hA5A5A5A5);
    // Forwarding: full word vs partial word
    step(0, 1, 4'h0, 14'h30, 32'hDEADBEEF, 0, 0);
    step(1, 0, 4'hF, 14'h30, 32'h0, 0, 32'h0);
`ifdef STB_FWD_EN
    chk("fwd_rdata", s_rdata, 32'hDEADBEEF);
    chk("fwd_stall", 32'(s_stall), 32'h0);
`else
    chk("nofwd_stall", 32'(s_stall), 32'h1);
`endif
    flush();
    step(0, 1, 4'hC, 14'h30, 32'hDEADBEEF, 0, 0);
    step(1, 0, 4'hF, 14'h30, 32'h0, 0, 32'h0);
    chk("part_stall", 32'(s_stall), 32'h1);
    flush();
    // Non-hit load owns the port; pending store waits
    step(0, 1, 4'h0, 14'h50, 32'h5, 0, 0);
    step(1, 0, 4'hF, 14'h40, 32'h0, 1, 32'h12345678);
    chk("ld_rdata", s_rdata, 32'h12345678);
    chk("ld_stall", 32'(s_stall), 32'h0);
    chk("ld_oe", 32'(s_oe), 32'h1);
    idle(0);
    chk("ld_nodrain", 32'(s_empty), 32'h0);
    flush();
    // Random traffic; a stalled request is held stable
    rd = 0; wr = 0; wen = 4'hF; a = 0; wd = 0; s_stall = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!s_stall) begin
        case ($urandom_range(0, 2))
          0: begin rd = 0; wr = 0; end
          1: begin rd = 1; wr = 0; end
          default: begin rd = 0; wr = 1; end
        endcase
        a = 14'($urandom_range(0, 7));
        wd = $urandom;
        wen = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      end
      g = $urandom_range(0, 3) != 0;
      step(rd, wr, wen, a, wd, g, $urandom);
    end
    flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
